// File: rtl/key_pkg.sv
// Shared definitions for the key debounce array: one-hot channel states
// and the counter-width helper used by every channel.
package key_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    FILTER1 = 4'b0010,
    STABLE  = 4'b0100,
    FILTER2 = 4'b1000
  } key_fsm_e;

  // One counter serves debounce, hold and repeat timing, so it is sized for the largest.
  function automatic int unsigned cnt_width(input int unsigned deb_cycles,
                                            input int unsigned long_cycles,
                                            input int unsigned repeat_cycles);
    int unsigned max_cycles;
    max_cycles = deb_cycles;
    if (long_cycles > max_cycles) max_cycles = long_cycles;
    if (repeat_cycles > max_cycles) max_cycles = repeat_cycles;
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-FF synchroniser, debounce FSM, shared counter, registered pulses.
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_long,
  output logic key_repeat,
  output logic key_state
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  logic          sync1_q;
  logic          key_s_q;
  key_fsm_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_done_q, long_done_d;
  logic          key_flag_q, key_flag_d;
  logic          key_release_q, key_release_d;
  logic          key_long_q, key_long_d;
  logic          key_state_q, key_state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      key_s_q       <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      long_done_q   <= 1'b0;
      key_flag_q    <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
      key_state_q   <= 1'b1;
    end else begin
      sync1_q       <= key_in;
      key_s_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      long_done_q   <= long_done_d;
      key_flag_q    <= key_flag_d;
      key_release_q <= key_release_d;
      key_long_q    <= key_long_d;
      key_state_q   <= key_state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!key_s_q) state_d = FILTER1;
      end
      FILTER1: begin
        if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = STABLE;
          cnt_d       = '0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE: begin
        if (key_s_q) begin
          state_d = FILTER2;
          cnt_d   = '0;
        end else if (!long_done_q) begin
          if (cnt_q == LONG_LAST) begin
            cnt_d       = '0;
            long_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
`ifdef KEY_AUTO_REPEAT_EN
          cnt_d = (cnt_q == REP_LAST) ? '0 : cnt_q + CW'(1);
`else
          cnt_d = '0;
`endif
        end
      end
      FILTER2: begin
        if (!key_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        long_done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    key_flag_d    = (state_q == FILTER1) && !key_s_q && (cnt_q == DEB_LAST);
    key_release_d = (state_q == FILTER2) && key_s_q && (cnt_q == DEB_LAST);
    key_long_d    = (state_q == STABLE) && !key_s_q && !long_done_q && (cnt_q == LONG_LAST);
    key_state_d   = !((state_q == STABLE) || (state_q == FILTER2));
  end

`ifdef KEY_AUTO_REPEAT_EN
  logic key_repeat_q, key_repeat_d;

  always_comb begin
    key_repeat_d = (state_q == STABLE) && !key_s_q && long_done_q && (cnt_q == REP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_repeat_q <= 1'b0;
    else        key_repeat_q <= key_repeat_d;
  end

  assign key_repeat = key_repeat_q;
`else
  assign key_repeat = 1'b0;
`endif

  assign key_flag    = key_flag_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign key_state   = key_state_q;

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent key_chan conditioners, one per active-low key pin.
// Optional auto-repeat is enabled by defining KEY_AUTO_REPEAT_EN.
module key_debounce_array #(
  parameter int unsigned KEY_NUM       = 4,
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat,
  output logic [KEY_NUM-1:0] key_state
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[i]),
      .key_flag   (key_flag[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_repeat (key_repeat[i]),
      .key_state  (key_state[i])
    );
  end

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Multi-channel, parametrised push-button conditioner for the front-panel key inputs. Each channel synchronises one active-low key, debounces press and release with glitch rejection, and emits press, release, long-press and optional auto-repeat pulses plus a stable level. It sits between the raw key pins and the control logic, such as DDS frequency/phase step selection.

## Interface
- `KEY_NUM`, default 4: number of independent key channels (≥1).
- `DEB_CYCLES`, default 1_000_000: debounce window in clocks (20 ms at 50 MHz); ≥2.
- `LONG_CYCLES`, default 50_000_000: hold time after confirmed press before `key_long` fires (1 s); must be > `DEB_CYCLES`.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after `key_long` (200 ms); ≥2.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_in` in KEY_NUM: raw keys, 0 = pressed.
- `key_flag` out KEY_NUM: one-cycle pulse on a confirmed press.
- `key_release` out KEY_NUM: one-cycle pulse on a confirmed release.
- `key_long` out KEY_NUM: one-cycle pulse once per hold, when the hold reaches `LONG_CYCLES`.
- `key_repeat` out KEY_NUM: one-cycle repeat pulses (see Configuration).
- `key_state` out KEY_NUM: debounced level, 1 = released, 0 = pressed.

## Operation
- **Reset values:** all outputs are 0 except `key_state`, which is all 1s. Sync flops reset to 1, state to IDLE, counters to 0, `long_done` to 0.
- **Synchronisation:** per channel, a 2-FF synchroniser produces `key_s`.
- **Channel FSM:** one-hot, states IDLE, FILTER1, STABLE, FILTER2. The counter `cnt` is per channel, width `$clog2` of the max of the three parameters.
- **IDLE:**
  - `key_s`=0 → FILTER1, `cnt`←0.
- **FILTER1:** `cnt` increments each cycle.
  - `key_s`=1 → IDLE. This is glitch rejection: no pulse.
  - `cnt`==DEB_CYCLES-1 with `key_s`=0 → STABLE, `cnt`←0, `long_done`←0. `key_flag` is registered high for 1 cycle.
- **STABLE:** `cnt` counts the hold time.
  - `key_s`=1 → FILTER2, `cnt`←0.
  - `long_done`=0 and `cnt`==LONG_CYCLES-1 → `key_long` pulse, `long_done`←1, `cnt`←0.
  - `long_done`=1: behaviour depends on the macro (see Configuration).
- **FILTER2:**
  - `key_s`=0 → STABLE, `cnt`←0, `long_done` kept. There is no second `key_long` and no `key_flag`.
  - `cnt`==DEB_CYCLES-1 with `key_s`=1 → IDLE. `key_release` pulses for 1 cycle.
- **`key_state`:** registered from the current state; 0 when the state was STABLE or FILTER2 in the previous cycle.
- **Channel independence:** channels never interact. Simultaneous events on several channels produce pulses on the same edge.
- **Illegal state codes:** → IDLE.
- **Reset mid-operation:** everything returns to reset values at once. No release pulse is generated. A key still held after `rst_n` deasserts is treated as a new press.

## Timing
- Let edge 0 be the first clock that samples `key_in` low.
  - `key_s` goes low at edge 1.
  - FILTER1 is entered at edge 2.
  - `key_flag` is high in the cycle after edge DEB_CYCLES+2.
  - `key_state` goes 0 at edge DEB_CYCLES+3.
- Release is symmetric: `key_release` fires at edge R+DEB_CYCLES+2, and `key_state` returns to 1 one edge later.
- `key_long` fires LONG_CYCLES edges after STABLE entry.
- Repeat pulses follow every REPEAT_CYCLES edges.
- All pulses are exactly 1 cycle wide. Nothing is combinational from `key_in` to any output.

## Configuration
- **`KEY_AUTO_REPEAT_EN` defined:** in STABLE with `long_done`=1, `cnt` wraps at REPEAT_CYCLES-1, and `key_repeat` pulses on each wrap until the channel leaves STABLE.
- **`KEY_AUTO_REPEAT_EN` undefined:**
  - `key_repeat` is tied to 0.
  - After `key_long`, `cnt` holds at 0.
  - No repeat compare logic is built.

## Structure
- **Package `key_pkg`:**
  - one-hot state localparams (IDLE=4'b0001, FILTER1=4'b0010, STABLE=4'b0100, FILTER2=4'b1000);
  - a function that computes the counter width from the three cycle parameters.
- **Sub-module `key_chan`:** one channel (synchroniser, FSM, counter, output registers).
- **Top level:** instantiates `key_chan` KEY_NUM times in a generate loop and contains no other logic.

## Test plan
Bench parameters: KEY_NUM=4, DEB_CYCLES=16, LONG_CYCLES=64, REPEAT_CYCLES=32.

1. Hold `rst_n`=0 for 5 clocks, keys high → all pulses 0, `key_state`=4'b1111; this holds for 50 clocks after release.
2. `key_in[0]` low at edge 0 for 40 clocks, then high → `key_flag[0]` 1-cycle pulse at edge 18, `key_state[0]`=0 from edge 19, `key_release[0]` pulse at edge 58, `key_state[0]`=1 from edge 59, no `key_long`.
3. `key_in[1]` low for 10 clocks, high for 20, then low and held → no pulse during the first glitch; `key_flag[1]` 18 edges after the second fall. A 5-clock high glitch during STABLE → no `key_release`, `key_state[1]` stays 0.
4. `key_in[2]` held low for 200 clocks from edge 0 → `key_flag` at 18, `key_long` at 82. With `KEY_AUTO_REPEAT_EN`: `key_repeat` at 114, 146, 178. Without it: `key_repeat` stays 0.
5. `key_in[0]` and `key_in[3]` fall on the same edge → both `key_flag` bits assert on the same edge (18); the other bits stay 0.
6. `key_in[0]` held; `rst_n` pulsed low at edge 30 for 3 clocks → outputs reset immediately, no `key_release`; `key_flag[0]` re-fires DEB_CYCLES+3 edges after `rst_n` rises.
